// File: rtl/trng_conditioner.sv
// Purpose: conditions a raw ring-oscillator bit stream into bytes using a Von Neumann debiaser.
// Latency: a byte is presented one clk after the sample strobe that accepts its 8th bit.
// Backpressure: single-entry output buffer; a byte that completes while the buffer is blocked is dropped and counted.
module trng_conditioner #(
    parameter int SAMPLE_DIV  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rnd_in,
    input  logic       enable,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic [7:0] drop_cnt
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAMPLE_DIV - 1);

    typedef enum logic {
        EMPTY,
        HAVE_FIRST
    } pair_state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [CNT_W-1:0]       smp_cnt;
    logic                   strobe;
    pair_state_t            state_q;
    pair_state_t            state_d;
    logic                   first_q;
    logic                   acc_vld;
    logic                   acc_dat;
    logic [7:0]             shreg;
    logic [2:0]             bit_cnt;
    logic                   byte_done;
    logic [7:0]             byte_dat;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign strobe   = enable && (smp_cnt == CNT_MAX);

    // Metastability chain for the asynchronous oscillator bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rnd_in};
        end
    end

    // Sample divider: held at zero while disabled so sampling restarts on a clean boundary.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            smp_cnt <= '0;
        end else if (strobe) begin
            smp_cnt <= '0;
        end else begin
            smp_cnt <= smp_cnt + CNT_W'(1);
        end
    end

    // Pair state register and capture of the first bit of each pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (strobe && state_q == EMPTY) begin
                first_q <= sync_bit;
            end
        end
    end

    // Von Neumann pairing: 01 -> 0, 10 -> 1, 00/11 discarded; disabling abandons a half pair.
    always_comb begin
        state_d = state_q;
        acc_vld = 1'b0;
        acc_dat = first_q;
        if (!enable) begin
            state_d = EMPTY;
        end else if (strobe) begin
            case (state_q)
                EMPTY: begin
                    state_d = HAVE_FIRST;
                end
                HAVE_FIRST: begin
                    state_d = EMPTY;
                    acc_vld = (first_q != sync_bit);
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    assign byte_done = acc_vld && (bit_cnt == 3'd7);
    assign byte_dat  = {shreg[6:0], acc_dat};

    // Byte assembly: first accepted bit ends up in the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg   <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (acc_vld) begin
            shreg   <= byte_dat;
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Output buffer: load when empty or draining this cycle, otherwise drop and count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            drop_cnt   <= 8'h00;
        end else if (byte_done) begin
            if (!byte_valid || byte_ready) begin
                byte_out   <= byte_dat;
                byte_valid <= 1'b1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (byte_valid && byte_ready) begin
            byte_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trng_conditioner.sv
module tb_trng_conditioner;

    localparam int SAMPLE_DIV  = 4;
    localparam int SYNC_STAGES = 2;

    logic       clk;
    logic       rst_n;
    logic       rnd_in;
    logic       enable;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] drop_cnt;

    int tests_run;
    int tests_failed;

    bit         stim[$];
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    int         vld_cycles;
    int         unstable;
    logic       prev_vld;
    logic       prev_rdy;
    logic [7:0] prev_byte;

    trng_conditioner #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rnd_in    (rnd_in),
        .enable    (enable),
        .byte_out  (byte_out),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observe delivered bytes, valid cycles and hold-stability just after each falling edge.
    initial begin
        vld_cycles = 0;
        unstable   = 0;
        prev_vld   = 1'b0;
        prev_rdy   = 1'b0;
        prev_byte  = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (prev_vld && !prev_rdy && rst_n && (!byte_valid || byte_out != prev_byte))
                unstable++;
            if (byte_valid === 1'b1) vld_cycles++;
            if (rst_n && byte_valid === 1'b1 && byte_ready) got.push_back(byte_out);
            prev_vld  = rst_n && (byte_valid === 1'b1);
            prev_rdy  = byte_ready;
            prev_byte = byte_out;
        end
    end

    // Reference: pair up samples, keep the first bit of unequal pairs, pack 8 MSB-first.
    function automatic void build_expected();
        logic [7:0] acc;
        int         n;
        exp_q.delete();
        acc = 8'h00;
        n   = 0;
        for (int i = 0; i + 1 < stim.size(); i += 2) begin
            if (stim[i] != stim[i+1]) begin
                acc = {acc[6:0], stim[i]};
                n++;
                if (n == 8) begin
                    exp_q.push_back(acc);
                    n = 0;
                end
            end
        end
    endfunction

    task automatic add_pairs(input bit a, input bit b, input int n);
        for (int i = 0; i < n; i++) begin
            stim.push_back(a);
            stim.push_back(b);
        end
    endtask

    task automatic add_byte(input logic [7:0] v);
        bit x;
        for (int i = 7; i >= 0; i--) begin
            if ($urandom_range(0, 3) == 0) begin
                x = 1'($urandom_range(0, 1));
                add_pairs(x, x, 1);
            end
            add_pairs(v[i], ~v[i], 1);
        end
    endtask

    // Holds one raw value for a full sample period; called and returns on a falling edge.
    task automatic sample(input bit b);
        rnd_in = b;
        repeat (SAMPLE_DIV) @(negedge clk);
    endtask

    task automatic play(input int flush);
        foreach (stim[i]) sample(stim[i]);
        repeat (flush) @(negedge clk);
    endtask

    task automatic apply_reset();
        enable = 1'b1;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
    endtask

    task automatic test_reset();
        enable     = 1'b1;
        byte_ready = 1'b1;
        rnd_in     = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        tests_run++;
        if (byte_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b want 0", byte_valid);
        end
        tests_run++;
        if (byte_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_byte: got %h want 00", byte_out);
        end
        tests_run++;
        if (drop_cnt !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_drop: got %h want 00", drop_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_pattern(input string name, input bit a, input bit b, input bit alt);
        int n0;
        int v0;
        apply_reset();
        byte_ready = 1'b1;
        stim.delete();
        for (int i = 0; i < 8; i++) begin
            if (alt && i % 2 == 1) add_pairs(b, a, 1);
            else add_pairs(a, b, 1);
        end
        build_expected();
        n0 = got.size();
        v0 = vld_cycles;
        play(2 * SAMPLE_DIV);
        tests_run++;
        if (got.size() - n0 != 1 || got[got.size()-1] !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL %s: got %0d bytes last %h want 1 byte %h", name, got.size() - n0,
                     (got.size() > 0) ? got[got.size()-1] : 8'h00, exp_q[0]);
        end
        tests_run++;
        if (vld_cycles - v0 != 1) begin
            tests_failed++;
            $display("FAIL %s_vld_cycles: got %0d want 1", name, vld_cycles - v0);
        end
        tests_run++;
        if (drop_cnt !== 8'h00) begin
            tests_failed++;
            $display("FAIL %s_drop: got %h want 00", name, drop_cnt);
        end
    endtask

    task automatic test_latency();
        apply_reset();
        byte_ready = 1'b1;
        stim.delete();
        add_pairs(1'b1, 1'b0, 7);
        stim.push_back(1'b1);
        play(0);
        rnd_in = 1'b0;
        repeat (SAMPLE_DIV - 1) @(negedge clk);
        tests_run++;
        if (byte_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_early: got valid %b want 0", byte_valid);
        end
        @(negedge clk);
        tests_run++;
        if (byte_valid !== 1'b1 || byte_out !== 8'hFF) begin
            tests_failed++;
            $display("FAIL latency_edge: got valid %b byte %h want 1 ff", byte_valid, byte_out);
        end
        repeat (2 * SAMPLE_DIV) @(negedge clk);
    endtask

    task automatic test_constant_one();
        int n0;
        int v0;
        apply_reset();
        byte_ready = 1'b1;
        rnd_in     = 1'b1;
        n0 = got.size();
        v0 = vld_cycles;
        repeat (1000) @(negedge clk);
        tests_run++;
        if (vld_cycles != v0 || got.size() != n0) begin
            tests_failed++;
            $display("FAIL constant_one: got %0d valid cycles want 0", vld_cycles - v0);
        end
    endtask

    task automatic test_random(input int pairs);
        int n0;
        bit x;
        apply_reset();
        byte_ready = 1'b1;
        stim.delete();
        for (int i = 0; i < 2 * pairs; i++) begin
            x = 1'($urandom_range(0, 1));
            stim.push_back(x);
        end
        build_expected();
        n0 = got.size();
        play(2 * SAMPLE_DIV);
        tests_run++;
        if (got.size() - n0 != exp_q.size()) begin
            tests_failed++;
            $display("FAIL random_count: got %0d want %0d", got.size() - n0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && n0 + i < got.size(); i++) begin
            tests_run++;
            if (got[n0+i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL random_byte%0d: got %h want %h", i, got[n0+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n0;
        int u0;
        apply_reset();
        byte_ready = 1'b0;
        stim.delete();
        for (int i = 0; i < 3; i++) add_byte(8'($urandom_range(0, 255)));
        build_expected();
        n0 = got.size();
        u0 = unstable;
        play(2 * SAMPLE_DIV);
        tests_run++;
        if (byte_valid !== 1'b1 || byte_out !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL bp_hold: got valid %b byte %h want 1 %h", byte_valid, byte_out, exp_q[0]);
        end
        tests_run++;
        if (drop_cnt !== 8'd2) begin
            tests_failed++;
            $display("FAIL bp_drop: got %0d want 2", drop_cnt);
        end
        tests_run++;
        if (unstable != u0 || got.size() != n0) begin
            tests_failed++;
            $display("FAIL bp_stable: got %0d changes %0d deliveries want 0 0", unstable - u0, got.size() - n0);
        end
        byte_ready = 1'b1;
        @(negedge clk);
        byte_ready = 1'b0;
        tests_run++;
        if (byte_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_release: got valid %b want 0", byte_valid);
        end
        tests_run++;
        if (got.size() != n0 + 1 || got[got.size()-1] !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL bp_delivered: got %0d bytes want 1 byte %h", got.size() - n0, exp_q[0]);
        end
    endtask

    task automatic test_drop_saturation();
        int exp_drop;
        apply_reset();
        byte_ready = 1'b0;
        stim.delete();
        add_pairs(1'b1, 1'b0, 8 * 258);
        build_expected();
        exp_drop = (exp_q.size() - 1 > 255) ? 255 : exp_q.size() - 1;
        play(2 * SAMPLE_DIV);
        tests_run++;
        if (drop_cnt !== 8'(exp_drop)) begin
            tests_failed++;
            $display("FAIL drop_saturate: got %0d want %0d", drop_cnt, exp_drop);
        end
        byte_ready = 1'b1;
    endtask

    task automatic test_reset_midstream();
        int n0;
        // Held byte under backpressure is discarded by reset.
        apply_reset();
        byte_ready = 1'b0;
        stim.delete();
        add_pairs(1'b1, 1'b0, 8);
        play(2 * SAMPLE_DIV);
        apply_reset();
        tests_run++;
        if (byte_valid !== 1'b0 || byte_out !== 8'h00 || drop_cnt !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_held: got valid %b byte %h drop %h want 0 00 00", byte_valid, byte_out, drop_cnt);
        end
        // Five accepted bits then reset leave no residue.
        byte_ready = 1'b1;
        stim.delete();
        add_pairs(1'b0, 1'b1, 5);
        play(2 * SAMPLE_DIV);
        apply_reset();
        stim.delete();
        add_pairs(1'b1, 1'b0, 8);
        build_expected();
        n0 = got.size();
        play(2 * SAMPLE_DIV);
        tests_run++;
        if (got.size() - n0 != 1 || got[got.size()-1] !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL reset_partial: got %0d bytes last %h want 1 byte %h", got.size() - n0,
                     (got.size() > 0) ? got[got.size()-1] : 8'h00, exp_q[0]);
        end
    endtask

    task automatic test_enable_gap();
        int n0;
        apply_reset();
        byte_ready = 1'b1;
        stim.delete();
        add_pairs(1'b1, 1'b0, 3);
        stim.push_back(1'b1);
        n0 = got.size();
        play(0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        stim.delete();
        add_pairs(1'b0, 1'b1, 5);
        play(2 * SAMPLE_DIV);
        // The orphaned first sample is abandoned; the partial byte survives.
        stim.delete();
        add_pairs(1'b1, 1'b0, 3);
        add_pairs(1'b0, 1'b1, 5);
        build_expected();
        tests_run++;
        if (got.size() - n0 != 1 || got[got.size()-1] !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL enable_gap: got %0d bytes last %h want 1 byte %h", got.size() - n0,
                     (got.size() > 0) ? got[got.size()-1] : 8'h00, exp_q[0]);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        enable       = 1'b1;
        rnd_in       = 1'b0;
        byte_ready   = 1'b1;
        @(negedge clk);
        test_reset();
        test_pattern("pairs_10_ff", 1'b1, 1'b0, 1'b0);
        test_pattern("alt_aa", 1'b1, 1'b0, 1'b1);
        test_pattern("pairs_01_00", 1'b0, 1'b1, 1'b0);
        test_latency();
        test_constant_one();
        test_random(48);
        test_random(64);
        test_backpressure();
        test_reset_midstream();
        test_enable_gap();
        test_drop_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/trng_conditioner.md
TRNG_CONDITIONER -- requirements
Module: trng_conditioner

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 16, meaning clk cycles between raw-bit samples (legal range 2..256).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flop depth of the rnd_in synchronizer (legal range 2..4).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port rnd_in  input  1  raw ring-oscillator bit, asynchronous to clk.
REQ-006 SHALL have port enable  input  1  sampling enable; sampling is active when high.
REQ-007 SHALL have port byte_out  output  8  conditioned random byte.
REQ-008 SHALL have port byte_valid  output  1  byte_out holds an undelivered byte.
REQ-009 SHALL have port byte_ready  input  1  downstream consumer (UART TX) accepts byte_out.
REQ-010 SHALL have port drop_cnt  output  8  count of completed bytes discarded under backpressure.

Function
REQ-011 SHALL pass rnd_in through a SYNC_STAGES-deep flop chain; only the last stage (sync_bit) feeds logic.
REQ-012 SHALL run a sample counter 0..SAMPLE_DIV-1 while enable=1; a strobe SHALL be asserted in the cycle the counter equals SAMPLE_DIV-1, and the counter SHALL then wrap to 0.
REQ-013 While enable=0, the sample counter SHALL be held at 0, no strobe SHALL occur, and the pair state SHALL be cleared; the partial byte and output buffer SHALL be retained.
REQ-014 Von Neumann pair FSM SHALL have states EMPTY and HAVE_FIRST; on strobe in EMPTY it SHALL store sync_bit as first and move to HAVE_FIRST.
REQ-015 On strobe in HAVE_FIRST it SHALL return to EMPTY, and, only if first != sync_bit, emit first as one accepted bit; pairs 00 and 11 SHALL be discarded.
REQ-016 Each accepted bit SHALL shift into an 8-bit shift register as {shreg[6:0], bit}, so the first accepted bit of a byte ends in byte_out[7]; a 3-bit counter SHALL track bits 0..7.
REQ-017 When the 8th bit is accepted, the completed byte SHALL be offered to the output buffer in that same cycle, and the bit counter SHALL wrap to 0.
REQ-018 The output buffer SHALL load the completed byte and set byte_valid=1 at the next edge if it is empty, or if byte_valid=1 and byte_ready=1 in that cycle; in the latter case byte_valid SHALL stay 1.
REQ-019 If the buffer is full and byte_ready=0 when a byte completes, the new byte SHALL be discarded, the held byte SHALL be kept, and drop_cnt SHALL increment, saturating at 255.
REQ-020 byte_valid SHALL be held and byte_out SHALL be stable until a cycle with byte_ready=1; byte_valid SHALL clear on that edge unless a new byte loads per REQ-018.
REQ-021 byte_ready while byte_valid=0 SHALL have no effect.
REQ-022 Latency: a completed byte SHALL appear on byte_out/byte_valid one clk after the strobe that accepted its 8th bit.

Reset
REQ-023 When rst_n=0 at a clk edge, all state SHALL clear: synchronizer flops, sample counter, FSM=EMPTY, shreg, and bit counter to 0.
REQ-024 Reset values SHALL be byte_out=0x00, byte_valid=0, drop_cnt=0x00, and SHALL be visible after the first edge with rst_n=0.
REQ-025 Reset mid-byte or mid-handshake SHALL discard the partial byte and any held byte without a handshake.

Verification (SAMPLE_DIV=4, SYNC_STAGES=2, byte_ready=1 unless stated)
REQ-026 rnd_in pairs 1,0 repeated for 8 pairs -> exactly one byte 0xFF, byte_valid high 1 cycle, drop_cnt=0.
REQ-027 rnd_in pairs 1,0 / 0,1 alternating for 8 pairs -> byte 0xAA; pairs 0,1 only -> 0x00.
REQ-028 rnd_in constant 1 for 1000 cycles -> byte_valid never asserts.
REQ-029 byte_ready=0 while 3 bytes complete -> first byte held stable, drop_cnt=2; then byte_ready=1 for 1 cycle -> byte_valid=0 next cycle.
REQ-030 rst_n pulsed low after 5 accepted bits, then 8 pairs 1,0 -> one byte 0xFF; no residue of the pre-reset bits.
REQ-031 enable=0 between the two samples of a pair, then enable=1 -> the pair is restarted, and the sample counter resumes from 0.
